// File: rtl/fp_pkg.sv
// Shared binary32 helpers for the FPU datapath: rounding-mode codes, field
// constants, input classification and the result payload.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int unsigned BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  localparam int unsigned QBITS = 27;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned EXP_W = 10;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic [31:0] z;
    logic        ovrf;
    logic        udrf;
  } fp_res_t;

  // Subnormals fold into FP_ZERO (flush-to-zero datapath).
  function automatic fp_class_e classify(input logic [31:0] x);
    if (x[30:23] == 8'h00)          return FP_ZERO;
    else if (x[30:23] != EXP_MAX)   return FP_NORM;
    else if (x[22:0] == 23'd0)      return FP_INF;
    else                            return FP_NAN;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Rounds a normalised mantissa with guard/round/sticky bits and packs the
// binary32 result, saturating or flushing on exponent range violations.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] e,
  input  logic [22:0]      frac,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  input  logic [2:0]       r_mode,
  output logic [31:0]      fp_Z,
  output logic             ovrf,
  output logic             udrf
);

  logic             inc;
  logic             ovf_to_inf;
  logic [23:0]      sum;
  logic [EXP_W-1:0] e_r;

  always_comb begin
    inc        = 1'b0;
    ovf_to_inf = 1'b1;
    case (r_mode)
      RM_RTZ: begin inc = 1'b0;               ovf_to_inf = 1'b0;  end
      RM_RDN: begin inc = sign & (g | r | s);  ovf_to_inf = sign;  end
      RM_RUP: begin inc = ~sign & (g | r | s); ovf_to_inf = ~sign; end
      RM_RMM: begin inc = g;                   ovf_to_inf = 1'b1;  end
      default: begin inc = g & (r | s | frac[0]); ovf_to_inf = 1'b1; end
    endcase

    // A carry out leaves sum[22:0] all-zero, which is exactly the new fraction.
    sum = {1'b0, frac} + 24'(inc);
    e_r = sum[23] ? EXP_W'(e + EXP_W'(1)) : e;

    fp_Z = {sign, e_r[7:0], sum[22:0]};
    ovrf = 1'b0;
    udrf = 1'b0;
    if ($signed(e_r) >= $signed(EXP_W'(255))) begin
      ovrf = 1'b1;
      fp_Z = ovf_to_inf ? {sign, EXP_MAX, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
    end else if ($signed(e_r) <= $signed(EXP_W'(0))) begin
      udrf = 1'b1;
      fp_Z = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, then shared round/pack logic.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [31:0]      x_q, y_q;
  logic [2:0]       rm_q;
  logic             sign_q;
  logic [EXP_W-1:0] e_q;
  logic [23:0]      my_q;
  logic [24:0]      rem_q;
  logic [QBITS-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  fp_res_t          res_q;

  logic             accept;
  fp_class_e        cls_x, cls_y;
  logic             special_c;
  fp_res_t          spec_c;
  logic             ge;
  logic [23:0]      diff;
  logic             norm;
  logic [22:0]      frac_c;
  logic             g_c, r_c, s_c;
  logic [EXP_W-1:0] e_c;
  logic [31:0]      rp_z;
  logic             rp_o, rp_u;

  assign accept = (state == S_IDLE) && start && !done;

  // Special-operand resolution, evaluated in CHECK on the latched operands.
  always_comb begin
    cls_x     = classify(x_q);
    cls_y     = classify(y_q);
    special_c = 1'b1;
    spec_c    = '{z: {x_q[31] ^ y_q[31], 31'd0}, ovrf: 1'b0, udrf: 1'b0};
    if (cls_x == FP_NAN || cls_y == FP_NAN ||
        (cls_x == FP_ZERO && cls_y == FP_ZERO) ||
        (cls_x == FP_INF && cls_y == FP_INF)) begin
      spec_c.z = QNAN;
    end else if (cls_x == FP_INF || cls_y == FP_ZERO) begin
      spec_c.z = {x_q[31] ^ y_q[31], EXP_MAX, 23'd0};
    end else if (cls_x == FP_ZERO || cls_y == FP_INF) begin
      spec_c.z = {x_q[31] ^ y_q[31], 31'd0};
    end else begin
      special_c = 1'b0;
    end
  end

  // The remainder stays below 2*mY, so a non-subtracting step never has bit 24 set.
  always_comb begin
    ge   = rem_q >= {1'b0, my_q};
    diff = ge ? 24'(rem_q - {1'b0, my_q}) : rem_q[23:0];
  end

  always_comb begin
    norm   = q_q[QBITS-1];
    frac_c = norm ? q_q[25:3] : q_q[24:2];
    g_c    = norm ? q_q[2] : q_q[1];
    r_c    = norm ? q_q[1] : q_q[0];
    s_c    = (norm & q_q[0]) | (rem_q != 25'd0);
    e_c    = e_q + EXP_W'(norm);
  end

  fp_round_pack u_round_pack (
    .sign   (sign_q),
    .e      (e_c),
    .frac   (frac_c),
    .g      (g_c),
    .r      (r_c),
    .s      (s_c),
    .r_mode (rm_q),
    .fp_Z   (rp_z),
    .ovrf   (rp_o),
    .udrf   (rp_u)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CHECK;
      S_CHECK: state_nxt = special_c ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == CNT_W'(QBITS - 1)) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      fp_Z   <= 32'd0;
      ovrf   <= 1'b0;
      udrf   <= 1'b0;
      x_q    <= 32'd0;
      y_q    <= 32'd0;
      rm_q   <= RM_RNE;
      sign_q <= 1'b0;
      e_q    <= '0;
      my_q   <= 24'd0;
      rem_q  <= 25'd0;
      q_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      busy <= (state_nxt == S_ITER) || (state_nxt == S_ROUND) || (state_nxt == S_DONE);
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (accept) begin
          x_q  <= fp_X;
          y_q  <= fp_Y;
          rm_q <= r_mode;
        end
        S_CHECK: begin
          res_q  <= spec_c;
          sign_q <= x_q[31] ^ y_q[31];
          rem_q  <= {2'b01, x_q[22:0]};
          my_q   <= {1'b1, y_q[22:0]};
          q_q    <= '0;
          cnt_q  <= '0;
          e_q    <= {2'b00, x_q[30:23]} - {2'b00, y_q[30:23]} + EXP_W'(BIAS - 1);
        end
        S_ITER: begin
          q_q   <= {q_q[QBITS-2:0], ge};
          rem_q <= {diff, 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_ROUND: res_q <= '{z: rp_z, ovrf: rp_o, udrf: rp_u};
        S_DONE: begin
          fp_Z <= res_q.z;
          ovrf <= res_q.ovrf;
          udrf <= res_q.udrf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors, handshake/abort
// scenarios and randomized operands against an integer-arithmetic model.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        busy;
  logic        done;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;

  int checks;
  int errs;

  fp_div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fp_X   (fp_X),
    .fp_Y   (fp_Y),
    .r_mode (r_mode),
    .busy   (busy),
    .done   (done),
    .fp_Z   (fp_Z),
    .ovrf   (ovrf),
    .udrf   (udrf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: quotient as an exact integer division, result {z, ovrf, udrf}.
  function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] rm);
    int     ex, ey, e;
    logic   sign, xz, yz, xi, yi, xn, yn, g, r, s, inc, to_inf;
    longint mx, my, num, q, mant;
    ex   = int'(x[30:23]);
    ey   = int'(y[30:23]);
    sign = x[31] ^ y[31];
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);  yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);  yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return {32'h7FC00000, 2'b00};
    if (xi || yz) return {sign, 8'hFF, 23'd0, 2'b00};
    if (xz || yi) return {sign, 31'd0, 2'b00};
    mx  = longint'(x[22:0]) + (longint'(1) << 23);
    my  = longint'(y[22:0]) + (longint'(1) << 23);
    num = mx << 26;
    q   = num / my;
    if (q >= (longint'(1) << 26)) begin
      mant = q >> 3; g = q[2]; r = q[1]; s = q[0] | (num % my != 0); e = ex - ey + 127;
    end else begin
      mant = q >> 2; g = q[1]; r = q[0]; s = (num % my != 0); e = ex - ey + 126;
    end
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (g | r | s);
      3'd3:    inc = !sign & (g | r | s);
      3'd4:    inc = g;
      default: inc = g & (r | s | mant[0]);
    endcase
    mant = mant + longint'(inc);
    if (mant == (longint'(1) << 24)) begin
      mant = longint'(1) << 23;
      e    = e + 1;
    end
    if (e >= 255) begin
      to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sign : (rm == 3'd3) ? !sign : 1'b1;
      return to_inf ? {sign, 8'hFF, 23'd0, 2'b10} : {sign, 8'hFE, 23'h7FFFFF, 2'b10};
    end
    if (e <= 0) return {sign, 31'd0, 2'b01};
    return {sign, 8'(e), 23'(mant), 2'b00};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [31:0] v;
    int          sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel < 5)  e = 8'($urandom_range(1, 254));
    else               e = 8'($urandom_range(100, 154));
    v = {1'($urandom), e, 23'($urandom)};
    if (sel == 1 && $urandom_range(0, 1) == 0) v[22:0] = 23'd0;
    return v;
  endfunction

  // Pulse start for one cycle; lat counts cycles from the accepting edge to done.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                       output int lat, output int bcnt);
    @(negedge clk);
    fp_X = x; fp_Y = y; r_mode = rm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm, input logic [31:0] ez, input logic eo,
                          input logic eu, input int elat);
    int lat, bcnt;
    do_op(x, y, rm, lat, bcnt);
    chk({tag, ".lat"},  32'(lat),  32'(elat));
    chk({tag, ".busy"}, 32'(bcnt), 32'(elat - 1));
    chk({tag, ".z"},    fp_Z,      ez);
    chk({tag, ".ovrf"}, 32'(ovrf), 32'(eo));
    chk({tag, ".udrf"}, 32'(udrf), 32'(eu));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ndone, c1, c2, stable, elat;
    logic [31:0] z1, z2, x, y;
    logic [2:0]  rm;
    logic [33:0] ref_r;

    checks = 0; errs = 0;
    rst = 1'b1; start = 1'b0; fp_X = 32'd0; fp_Y = 32'd0; r_mode = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.z",    fp_Z,      32'd0);
    chk("reset.ovrf", 32'(ovrf), 32'd0);
    chk("reset.udrf", 32'(udrf), 32'd0);

    op_check("six_by_two",  32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0, 30);
    op_check("third.rne",   32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 1'b0, 1'b0, 30);
    op_check("third.rtz",   32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 1'b0, 1'b0, 30);
    op_check("third.rdn",   32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 1'b0, 1'b0, 30);
    op_check("ovf.rne",     32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 1'b1, 1'b0, 30);
    op_check("ovf.rtz",     32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0, 30);
    op_check("ovf.rup_neg", 32'hFF7FFFFF, 32'h3F000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0, 30);
    op_check("ovf.rdn_neg", 32'hFF7FFFFF, 32'h3F000000, 3'd2, 32'hFF800000, 1'b1, 1'b0, 30);
    op_check("udf",         32'h00800000, 32'h4B000000, 3'd0, 32'h00000000, 1'b0, 1'b1, 30);
    op_check("div_zero",    32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 1'b0, 1'b0, 2);
    op_check("zero_zero",   32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0, 2);

    // start held high: second request is only taken once done has dropped.
    @(negedge clk);
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; start = 1'b1;
    @(negedge clk);
    fp_X = 32'h3F800000; fp_Y = 32'h40400000;
    ndone = 0; c1 = -1; c2 = -1; stable = 1; z1 = 32'd0; z2 = 32'd0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin c1 = c; z1 = fp_Z; end
        else if (ndone == 2) begin c2 = c; z2 = fp_Z; start = 1'b0; end
      end else if (ndone == 1 && fp_Z !== z1) begin
        stable = 0;
      end
    end
    start = 1'b0;
    chk("b2b.ndone",  32'(ndone),  32'd2);
    chk("b2b.first",  32'(c1),     32'd30);
    chk("b2b.second", 32'(c2),     32'd62);
    chk("b2b.z1",     z1,          32'h40400000);
    chk("b2b.z2",     z2,          32'h3EAAAAAB);
    chk("b2b.stable", 32'(stable), 32'd1);

    // Abort mid-operation.
    @(negedge clk);
    fp_X = 32'h3F800000; fp_Y = 32'h40400000; r_mode = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.z",    fp_Z,      32'd0);
    chk("abort.ovrf", 32'(ovrf), 32'd0);
    chk("abort.udrf", 32'(udrf), 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    op_check("post_abort", 32'h41100000, 32'h40400000, 3'd0, 32'h40400000, 1'b0, 1'b0, 30);

    for (int i = 0; i < 60; i++) begin
      x  = rand_fp();
      y  = rand_fp();
      rm = 3'($urandom_range(0, 7));
      ref_r = ref_div(x, y, rm);
      elat = (x[30:23] == 8'h00 || x[30:23] == 8'hFF ||
              y[30:23] == 8'h00 || y[30:23] == 8'hFF) ? 2 : 30;
      op_check($sformatf("rnd%0d_%08h_%08h_m%0d", i, x, y, rm), x, y, rm,
               ref_r[33:2], ref_r[1], ref_r[0], elat);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
